// File: rtl/led_status_ctrl.sv
// +----------------------------------------------------------------------------+
// | led_status_ctrl: per-channel board LED driver (static, heartbeat, gated     |
// | blink, activity stretch) with input sync and a shared millisecond tick.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_status_ctrl #(
  parameter int NumLeds     = 3,
  parameter int PrescaleDiv = 50000,
  parameter int BlinkMs     = 250,
  parameter int StretchMs   = 50
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  input  logic [2*NumLeds-1:0]   mode_i,
  input  logic [NumLeds-1:0]     level_i,
  input  logic [NumLeds-1:0]     act_i,
  output logic [NumLeds-1:0]     led_o,
  output logic                   tick_o
);

  localparam int C_PRE_W = $clog2(PrescaleDiv);
  localparam int C_PH_W  = (BlinkMs > 1) ? $clog2(BlinkMs) : 1;
  localparam int C_STR_W = $clog2(StretchMs + 1);

  localparam logic [C_PRE_W-1:0] C_PRE_MAX  = C_PRE_W'(PrescaleDiv - 1);
  localparam logic [C_PH_W-1:0]  C_PH_MAX   = C_PH_W'(BlinkMs - 1);
  localparam logic [C_STR_W-1:0] C_STR_LOAD = C_STR_W'(StretchMs);

  localparam logic [1:0] C_MODE_STATIC = 2'b00;
  localparam logic [1:0] C_MODE_HEART  = 2'b01;
  localparam logic [1:0] C_MODE_BLINK  = 2'b10;
  localparam logic [1:0] C_MODE_ACT    = 2'b11;

  logic [NumLeds-1:0] r_level_s1, r_level_s2;
  logic [NumLeds-1:0] r_act_s1, r_act_s2, r_act_s3;
  logic [C_PRE_W-1:0] r_pre_cnt;
  logic [C_PH_W-1:0]  r_ph_cnt;
  logic               r_phase;
  logic [NumLeds-1:0][C_STR_W-1:0] r_str_cnt;
  logic [NumLeds-1:0] w_act_edge;
  logic [NumLeds-1:0] w_led_nxt;
  logic               w_tick;

  assign w_tick     = (r_pre_cnt == C_PRE_MAX);
  assign tick_o     = w_tick;
  assign w_act_edge = r_act_s2 ^ r_act_s3;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_level_s1 <= '0;
      r_level_s2 <= '0;
      r_act_s1   <= '0;
      r_act_s2   <= '0;
      r_act_s3   <= '0;
    end else begin
      r_level_s1 <= level_i;
      r_level_s2 <= r_level_s1;
      r_act_s1   <= act_i;
      r_act_s2   <= r_act_s1;
      r_act_s3   <= r_act_s2;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_pre_cnt <= '0;
      r_ph_cnt  <= '0;
      r_phase   <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + C_PRE_W'(1);
      if (w_tick) begin
        if (r_ph_cnt == C_PH_MAX) begin
          r_ph_cnt <= '0;
          r_phase  <= ~r_phase;
        end else begin
          r_ph_cnt <= r_ph_cnt + C_PH_W'(1);
        end
      end
    end
  end

  // A fresh edge always reloads, even on a tick, so retriggers never lose a tick.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_str_cnt <= '0;
    end else begin
      for (int i = 0; i < NumLeds; i++) begin
        if (w_act_edge[i]) begin
          r_str_cnt[i] <= C_STR_LOAD;
        end else if (w_tick && (r_str_cnt[i] != '0)) begin
          r_str_cnt[i] <= r_str_cnt[i] - C_STR_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < NumLeds; i++) begin
      case (mode_i[2*i +: 2])
        C_MODE_STATIC: w_led_nxt[i] = r_level_s2[i];
        C_MODE_HEART:  w_led_nxt[i] = r_phase;
        C_MODE_BLINK:  w_led_nxt[i] = r_level_s2[i] & r_phase;
        C_MODE_ACT:    w_led_nxt[i] = (r_str_cnt[i] != '0);
        default:       w_led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      led_o <= '0;
    end else begin
      led_o <= w_led_nxt;
    end
  end

endmodule

`default_nettype wire
